// File: rtl/sd_cmd_fsm_ctrl.sv
// sd_cmd_fsm_ctrl
// Command-path sequencer for the SD host. It owns the CMD state machine and the
// bit counters that drive the command send shift register. It also times the
// response (NCR) window and the post-command NCC gap.
// Optional feature: define SD_CMD_RESP_TIMEOUT_EN to enable the NCR response
// timeout. Without it, WAIT_RECEIVE holds until a start bit or a soft reset.
//
// state             | meaning
// IDLE         (0)  | waiting for in_cmd_start
// SEND         (1)  | 48 command bits shifted out, has_send_bit counts 0..47
// WAIT_RECEIVE (2)  | NCR window, looking for the response start bit
// RECEIVE      (3)  | response bits counted into has_receive_bit
// STOP         (4)  | NCC idle gap before returning to IDLE
// 5..7              | illegal, recover to IDLE on the next clock

module sd_cmd_fsm_ctrl #(
`ifdef SD_CMD_RESP_TIMEOUT_EN
    parameter int RESP_TIMEOUT = 64,
`endif
    parameter int NCC_CYCLES   = 8
) (
    input  logic       in_sd_clk,
    input  logic       hrst_n,
    input  logic       in_soft_reset,
    input  logic       in_cmd_start,
    input  logic [1:0] in_response_type,
    input  logic       in_sd_cmd_in,
    output logic [2:0] out_current_state,
    output logic [5:0] out_has_send_bit,
    output logic [7:0] out_has_receive_bit,
    output logic       out_cmd_busy,
    output logic       out_end_command,
    output logic       out_resp_timeout
);

    localparam logic [2:0] CMD_STATE_IDLE         = 3'd0;
    localparam logic [2:0] CMD_STATE_SEND         = 3'd1;
    localparam logic [2:0] CMD_STATE_WAIT_RECEIVE = 3'd2;
    localparam logic [2:0] CMD_STATE_RECEIVE      = 3'd3;
    localparam logic [2:0] CMD_STATE_STOP         = 3'd4;

    localparam logic [5:0] SEND_LAST     = 6'd47;
    localparam logic [7:0] RECV_LAST_48  = 8'd47;
    localparam logic [7:0] RECV_LAST_136 = 8'd135;

    localparam int               NCC_W    = (NCC_CYCLES > 1) ? $clog2(NCC_CYCLES) : 1;
    localparam logic [NCC_W-1:0] NCC_LAST = NCC_W'(NCC_CYCLES - 1);

    logic [2:0]       state_q;
    logic [2:0]       state_nxt;
    logic [1:0]       resp_type_q;
    logic [NCC_W-1:0] ncc_cnt_q;
    logic [7:0]       recv_last;
    logic             timeout_hit;

    assign out_current_state = state_q;

    // Only an explicit 136-bit request uses the long response; 11 behaves as 48-bit.
    assign recv_last = (resp_type_q == 2'b10) ? RECV_LAST_136 : RECV_LAST_48;

`ifdef SD_CMD_RESP_TIMEOUT_EN
    localparam int                WAIT_W    = (RESP_TIMEOUT > 1) ? $clog2(RESP_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(RESP_TIMEOUT - 1);

    logic [WAIT_W-1:0] wait_cnt_q;
    logic              resp_timeout_q;

    // A start bit seen on the last window cycle still wins over the timeout.
    assign timeout_hit      = (state_q == CMD_STATE_WAIT_RECEIVE) && in_sd_cmd_in &&
                              (wait_cnt_q == WAIT_LAST);
    assign out_resp_timeout = resp_timeout_q;

    // NCR window counter (restarts on each WAIT_RECEIVE entry) and sticky timeout flag
    always_ff @(posedge in_sd_clk or negedge hrst_n) begin
        if (!hrst_n) begin
            wait_cnt_q     <= '0;
            resp_timeout_q <= 1'b0;
        end else if (!in_soft_reset) begin
            wait_cnt_q     <= '0;
            resp_timeout_q <= 1'b0;
        end else begin
            if ((state_q == CMD_STATE_WAIT_RECEIVE) && (state_nxt == CMD_STATE_WAIT_RECEIVE))
                wait_cnt_q <= wait_cnt_q + 1'b1;
            else
                wait_cnt_q <= '0;

            if ((state_q == CMD_STATE_IDLE) && in_cmd_start)
                resp_timeout_q <= 1'b0;
            else if (timeout_hit)
                resp_timeout_q <= 1'b1;
        end
    end
`else
    assign timeout_hit      = 1'b0;
    assign out_resp_timeout = 1'b0;
`endif

    // Next-state decode
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            CMD_STATE_IDLE: begin
                if (in_cmd_start)
                    state_nxt = CMD_STATE_SEND;
            end
            CMD_STATE_SEND: begin
                if (out_has_send_bit == SEND_LAST)
                    state_nxt = (resp_type_q == 2'b00) ? CMD_STATE_STOP : CMD_STATE_WAIT_RECEIVE;
            end
            CMD_STATE_WAIT_RECEIVE: begin
                if (!in_sd_cmd_in)
                    state_nxt = CMD_STATE_RECEIVE;
                else if (timeout_hit)
                    state_nxt = CMD_STATE_STOP;
            end
            CMD_STATE_RECEIVE: begin
                if (out_has_receive_bit == recv_last)
                    state_nxt = CMD_STATE_STOP;
            end
            CMD_STATE_STOP: begin
                if (ncc_cnt_q == NCC_LAST)
                    state_nxt = CMD_STATE_IDLE;
            end
            default: state_nxt = CMD_STATE_IDLE;
        endcase
    end

    // State register, bit counters and registered status outputs
    always_ff @(posedge in_sd_clk or negedge hrst_n) begin
        if (!hrst_n) begin
            state_q             <= CMD_STATE_IDLE;
            resp_type_q         <= 2'b00;
            ncc_cnt_q           <= '0;
            out_has_send_bit    <= '0;
            out_has_receive_bit <= '0;
            out_cmd_busy        <= 1'b0;
            out_end_command     <= 1'b0;
        end else if (!in_soft_reset) begin
            state_q             <= CMD_STATE_IDLE;
            resp_type_q         <= 2'b00;
            ncc_cnt_q           <= '0;
            out_has_send_bit    <= '0;
            out_has_receive_bit <= '0;
            out_cmd_busy        <= 1'b0;
            out_end_command     <= 1'b0;
        end else begin
            state_q         <= state_nxt;
            out_cmd_busy    <= (state_nxt != CMD_STATE_IDLE);
            out_end_command <= (state_q == CMD_STATE_STOP) && (state_nxt == CMD_STATE_IDLE);

            if ((state_q == CMD_STATE_STOP) && (state_nxt == CMD_STATE_STOP))
                ncc_cnt_q <= ncc_cnt_q + 1'b1;
            else
                ncc_cnt_q <= '0;

            case (state_q)
                CMD_STATE_IDLE: begin
                    if (in_cmd_start) begin
                        out_has_send_bit    <= '0;
                        out_has_receive_bit <= '0;
                        resp_type_q         <= in_response_type;
                    end
                end
                CMD_STATE_SEND: begin
                    if (out_has_send_bit != SEND_LAST)
                        out_has_send_bit <= out_has_send_bit + 1'b1;
                end
                CMD_STATE_WAIT_RECEIVE: begin
                    // The start bit itself is the first received bit.
                    if (state_nxt == CMD_STATE_RECEIVE)
                        out_has_receive_bit <= 8'd1;
                end
                CMD_STATE_RECEIVE: begin
                    if (out_has_receive_bit != recv_last)
                        out_has_receive_bit <= out_has_receive_bit + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
